// File: rtl/alu_pkg.sv
// Shared opcode set and response-entry sizing for the ALU command responder.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    function automatic logic is_rsvd(input logic [2:0] sel);
        return sel > OP_NOT;
    endfunction

    // Entry layout: {illegal, zero, carry, result}
    function automatic int rsp_w(input int w);
        return w + 3;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; pointers carry an extra wrap bit for full/empty.
module alu_rsp_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    import alu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (push && !full) begin
                r_mem[r_wr[AW-1:0]] <= din;
                r_wr                <= r_wr + ONE;
            end
            if (pop && !empty) r_rd <= r_rd + ONE;
        end
    end

    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign dout  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/alu_cmd_responder.sv
// ALU command responder: evaluates accepted commands and queues flagged results.
module alu_cmd_responder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count
);
    import alu_pkg::*;

    localparam int EW = rsp_w(WIDTH);

    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ill;
    logic             w_zero;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_count;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ill   = 1'b0;
        unique case (1'b1)
            cmd_sel == OP_ADD: {w_carry, w_res} = {1'b0, cmd_a} + {1'b0, cmd_b};
            cmd_sel == OP_SUB: begin
                w_res   = cmd_a - cmd_b;
                w_carry = cmd_a < cmd_b;
            end
            cmd_sel == OP_AND: w_res = cmd_a & cmd_b;
            cmd_sel == OP_OR:  w_res = cmd_a | cmd_b;
            cmd_sel == OP_NOT: w_res = ~cmd_a;
            is_rsvd(cmd_sel):  w_ill = 1'b1;
            default: ;
        endcase
    end

    assign w_zero  = (w_res == '0);
    assign w_entry = {w_ill, w_zero, w_carry, w_res};

    // Ready depends only on stored fill, so a pop never frees a slot same-cycle
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign rsp_valid = !w_empty;
    assign w_pop     = rsp_valid && rsp_ready;

    alu_rsp_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_entry),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_head)
    );

    assign rsp_result  = w_head[WIDTH-1:0];
    assign rsp_carry   = w_head[WIDTH];
    assign rsp_zero    = w_head[WIDTH+1];
    assign rsp_illegal = w_head[WIDTH+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else if (w_pop) r_count <= r_count + CNT_W'(1);
    end

    assign op_count = r_count;

endmodule
